// File: rtl/add32_pkg.sv
// Shared types and constants for the add32 accumulate sequencer.
package add32_pkg;

    localparam int DW                = 32;
    localparam int SETTLE_CYCLES_MAX = 15;
    localparam int TIMER_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/add32_settle_timer.sv
// Loadable down-counter that times the adder's multicycle settle window.
module add32_settle_timer
    import add32_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/add32_accum_ctrl.sv
// Streams words through an external ripple-carry adder, sampling it only after a
// fixed settle window, and accumulates sum / carry count / word count per packet.
module add32_accum_ctrl
    import add32_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_last,
    output logic [DW-1:0]    add_a,
    output logic [DW-1:0]    add_b,
    input  logic [DW-1:0]    add_y,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_sum,
    output logic [CNT_W-1:0] out_carry_cnt,
    output logic [CNT_W-1:0] out_word_cnt
);

    // Out-of-range settings are clamped to the 1..15 window the 4-bit timer can express.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 :
                                (SETTLE_CYCLES > SETTLE_CYCLES_MAX) ? SETTLE_CYCLES_MAX :
                                SETTLE_CYCLES;
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_EFF - 1);

    state_e            state_q, state_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     add_a_q, add_a_d;
    logic [DW-1:0]     add_b_q, add_b_d;
    logic [CNT_W-1:0]  carry_cnt_q, carry_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              last_q, last_d;

    logic              timer_zero;
    logic              accept;
    logic              capture;
    logic              release_pkt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    assign accept      = in_valid && in_ready;
    assign capture     = (state_q == SETTLE) && timer_zero;
    assign release_pkt = (state_q == DONE) && out_ready;

    add32_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (SETTLE_LOAD),
        .dec      (state_q == SETTLE),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = SETTLE;
            SETTLE:  if (timer_zero) state_d = last_q ? DONE : IDLE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operands only change on accept or release, so the adder sees stable inputs all through SETTLE.
    always_comb begin
        acc_d       = acc_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        carry_cnt_d = carry_cnt_q;
        word_cnt_d  = word_cnt_q;
        last_d      = last_q;

        if (accept) begin
            add_a_d = acc_q;
            add_b_d = in_data;
            last_d  = in_last;
        end

        if (capture) begin
            acc_d       = add_y;
            carry_cnt_d = sat_inc(carry_cnt_q, add_cout);
            word_cnt_d  = sat_inc(word_cnt_q, 1'b1);
        end

        if (release_pkt) begin
            acc_d       = '0;
            add_a_d     = '0;
            carry_cnt_d = '0;
            word_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            carry_cnt_q <= '0;
            word_cnt_q  <= '0;
            last_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            carry_cnt_q <= carry_cnt_d;
            word_cnt_q  <= word_cnt_d;
            last_q      <= last_d;
        end
    end

    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign out_sum       = acc_q;
    assign out_carry_cnt = carry_cnt_q;
    assign out_word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_add32_accum_ctrl.sv
// Directed bench for add32_accum_ctrl: default instance plus a CNT_W=2 instance for saturation.
module tb_add32_accum_ctrl;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance (CNT_W=8)
    logic        in_valid, in_ready, in_last, out_valid, out_ready, add_cout;
    logic [31:0] in_data, add_a, add_b, add_y, out_sum;
    logic [7:0]  out_carry_cnt, out_word_cnt;

    // Saturation instance (CNT_W=2)
    logic        in_valid_s, in_ready_s, in_last_s, out_valid_s, out_ready_s, add_cout_s;
    logic [31:0] in_data_s, add_a_s, add_b_s, add_y_s, out_sum_s;
    logic [1:0]  out_carry_cnt_s, out_word_cnt_s;

    // Behavioural stand-in for the external adder
    assign {add_cout, add_y}     = {1'b0, add_a} + {1'b0, add_b};
    assign {add_cout_s, add_y_s} = {1'b0, add_a_s} + {1'b0, add_b_s};

    add32_accum_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_y(add_y), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry_cnt(out_carry_cnt), .out_word_cnt(out_word_cnt)
    );

    add32_accum_ctrl #(.SETTLE_CYCLES(S), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s), .in_last(in_last_s),
        .add_a(add_a_s), .add_b(add_b_s), .add_y(add_y_s), .add_cout(add_cout_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_sum(out_sum_s),
        .out_carry_cnt(out_carry_cnt_s), .out_word_cnt(out_word_cnt_s)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after capture.
    task automatic send_word(input logic [31:0] d, input logic last);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        in_last  = 1'b0;
        check("add_b_held", add_b, d);
        for (int i = 0; i < S; i++) begin
            check("in_ready_low_in_settle", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        if (!last) check("in_ready_after_capture", 32'(in_ready), 32'd1);
        else       check("out_valid_after_capture", 32'(out_valid), 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_cleared", 32'(out_valid), 32'd0);
        check("in_ready_after_release", 32'(in_ready), 32'd1);
        check("add_a_cleared", add_a, 32'd0);
    endtask

    task automatic send_word_s(input logic [31:0] d, input logic last);
        in_valid_s = 1'b1;
        in_data_s  = d;
        in_last_s  = last;
        @(negedge clk);
        in_valid_s = 1'b0;
        in_last_s  = 1'b0;
        repeat (S) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        in_valid_s = 1'b0; in_data_s = '0; in_last_s = 1'b0; out_ready_s = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_carry_cnt", 32'(out_carry_cnt), 32'd0);
        check("rst_word_cnt", 32'(out_word_cnt), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Packet 5, 7, 9
        send_word(32'd5, 1'b0);
        send_word(32'd7, 1'b0);
        send_word(32'd9, 1'b1);
        check("p1_sum", out_sum, 32'd21);
        check("p1_carry", 32'(out_carry_cnt), 32'd0);
        check("p1_words", 32'(out_word_cnt), 32'd3);
        take_result();

        // Wrapping packet
        send_word(32'hFFFF_FFFF, 1'b0);
        send_word(32'h0000_0002, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1);
        check("p2_sum", out_sum, 32'h0000_0000);
        check("p2_carry", 32'(out_carry_cnt), 32'd2);
        check("p2_words", 32'(out_word_cnt), 32'd3);
        take_result();

        // Single-word packet, then stall in DONE with in_valid high
        send_word(32'hDEAD_BEEF, 1'b1);
        check("p3_sum", out_sum, 32'hDEAD_BEEF);
        check("p3_carry", 32'(out_carry_cnt), 32'd0);
        check("p3_words", 32'(out_word_cnt), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        repeat (10) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_sum", out_sum, 32'hDEAD_BEEF);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_words", 32'(out_word_cnt), 32'd1);
        end
        in_valid = 1'b0;
        take_result();
        send_word(32'd10, 1'b1);
        check("p4_sum_from_zero", out_sum, 32'd10);
        check("p4_words", 32'(out_word_cnt), 32'd1);
        take_result();

        // out_ready held high outside DONE must not disturb accumulation
        out_ready = 1'b1;
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b1);
        check("p5_sum", out_sum, 32'd3);
        check("p5_words", 32'(out_word_cnt), 32'd2);
        @(negedge clk);
        out_ready = 1'b0;
        check("p5_released", 32'(out_valid), 32'd0);

        // Reset during SETTLE of the second word
        send_word(32'd100, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd200;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("abort_sum", out_sum, 32'd0);
        check("abort_words", 32'(out_word_cnt), 32'd0);
        check("abort_carry", 32'(out_carry_cnt), 32'd0);
        check("abort_add_a", add_a, 32'd0);
        check("abort_add_b", add_b, 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(32'd3, 1'b0);
        send_word(32'd4, 1'b1);
        check("p6_sum", out_sum, 32'd7);
        check("p6_carry", 32'(out_carry_cnt), 32'd0);
        check("p6_words", 32'(out_word_cnt), 32'd2);
        take_result();

        // Counter saturation with CNT_W=2
        for (int i = 0; i < 5; i++) send_word_s(32'hFFFF_FFFF, (i == 4));
        check("sat_out_valid", 32'(out_valid_s), 32'd1);
        check("sat_sum", out_sum_s, 32'hFFFF_FFFB);
        check("sat_carry", 32'(out_carry_cnt_s), 32'd3);
        check("sat_words", 32'(out_word_cnt_s), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
